// File: rtl/oric_pkg.sv
// rtl/oric_pkg.sv - shared tape-encoder states, defaults and parity helper
package oric_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tape_state_t;

    localparam int DEF_HALF_US   = 208;
    localparam int DEF_STOP_BITS = 4;
    localparam int TICK_W        = 10;

    // Parity cell is 1 when the byte holds an even number of ones (odd overall parity)
    function automatic logic odd_parity_bit(input logic [7:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/tape_bit_cell.sv
// rtl/tape_bit_cell.sv - one cassette cell: HALF_US high, then HALF_US ('1') or 2*HALF_US ('0') low
module tape_bit_cell
    import oric_pkg::*;
#(
    parameter int HALF_US = DEF_HALF_US
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    input  logic ena,
    input  logic freeze,
    output logic wave,
    output logic done
);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(HALF_US - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(2 * HALF_US - 1);

    logic              active;
    logic              low_phase;
    logic              cur_bit;
    logic [TICK_W-1:0] ticks;
    logic              step;
    logic [TICK_W-1:0] low_last;

    assign step     = active && ena && !freeze;
    assign low_last = cur_bit ? HALF_LAST : FULL_LAST;
    // done fires on the enable that ends the low phase, so the next cell can start on the same edge
    assign done     = step && low_phase && (ticks == low_last);

    // Cell phase/tick sequencer; a new start always wins so cells abut with no lost enable
    always_ff @(posedge clk) begin
        if (reset) begin
            active    <= 1'b0;
            low_phase <= 1'b0;
            cur_bit   <= 1'b1;
            ticks     <= '0;
            wave      <= 1'b1;
        end else if (start) begin
            active    <= 1'b1;
            low_phase <= 1'b0;
            cur_bit   <= bit_val;
            ticks     <= '0;
            wave      <= 1'b1;
        end else if (step) begin
            if (!low_phase) begin
                if (ticks == HALF_LAST) begin
                    low_phase <= 1'b1;
                    ticks     <= '0;
                    wave      <= 1'b0;
                end else begin
                    ticks <= ticks + 1'b1;
                end
            end else if (done) begin
                active    <= 1'b0;
                low_phase <= 1'b0;
                ticks     <= '0;
                wave      <= 1'b1;
            end else begin
                ticks <= ticks + 1'b1;
            end
        end
    end

endmodule

// File: rtl/oric_tape_encoder.sv
// rtl/oric_tape_encoder.sv - byte stream to Oric fast-format cassette waveform on K7_TAPEIN
module oric_tape_encoder
    import oric_pkg::*;
#(
    parameter int HALF_US   = DEF_HALF_US,
    parameter int STOP_BITS = DEF_STOP_BITS
) (
    input  logic       CLK_IN,
    input  logic       RESET,
    input  logic       ENA_1MHZ,
    input  logic       motor_on,
    input  logic [7:0] tap_data,
    input  logic       tap_valid,
    output logic       tap_ready,
    output logic       busy,
    output logic       K7_TAPEIN
);

    localparam int               STOP_W    = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

    tape_state_t       state;
    logic [7:0]        data_q;
    logic              parity_q;
    logic [2:0]        bit_idx;
    logic [STOP_W-1:0] stop_idx;
    logic              accept;
    logic              cell_start;
    logic              cell_bit;
    logic              cell_done;

    assign accept = (state == ST_IDLE) && tap_valid && tap_ready;

    // Choose the next cell to launch the moment the current one finishes
    always_comb begin
        cell_start = 1'b0;
        cell_bit   = 1'b1;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cell_start = 1'b1;
                    cell_bit   = 1'b0;
                end
            end
            ST_START: begin
                if (cell_done) begin
                    cell_start = 1'b1;
                    cell_bit   = data_q[0];
                end
            end
            ST_DATA: begin
                if (cell_done) begin
                    cell_start = 1'b1;
                    cell_bit   = (bit_idx == 3'd7) ? parity_q : data_q[bit_idx + 3'd1];
                end
            end
            ST_PARITY: begin
                if (cell_done) begin
                    cell_start = 1'b1;
                    cell_bit   = 1'b1;
                end
            end
            ST_STOP: begin
                if (cell_done && (stop_idx != STOP_LAST)) begin
                    cell_start = 1'b1;
                    cell_bit   = 1'b1;
                end
            end
            default: begin
                cell_start = 1'b0;
            end
        endcase
    end

    // Frame sequencer: start, eight data cells LSB first, parity, stop cells
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            parity_q  <= 1'b0;
            bit_idx   <= '0;
            stop_idx  <= '0;
            busy      <= 1'b0;
            tap_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        data_q    <= tap_data;
                        parity_q  <= odd_parity_bit(tap_data);
                        bit_idx   <= '0;
                        stop_idx  <= '0;
                        busy      <= 1'b1;
                        tap_ready <= 1'b0;
                        state     <= ST_START;
                    end else begin
                        tap_ready <= motor_on;
                    end
                end
                ST_START: begin
                    if (cell_done) begin
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cell_done) begin
                        if (bit_idx == 3'd7) begin
                            state <= ST_PARITY;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (cell_done) begin
                        stop_idx <= '0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cell_done) begin
                        if (stop_idx == STOP_LAST) begin
                            busy      <= 1'b0;
                            tap_ready <= motor_on;
                            state     <= ST_IDLE;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    tape_bit_cell #(
        .HALF_US (HALF_US)
    ) u_cell (
        .clk     (CLK_IN),
        .reset   (RESET),
        .start   (cell_start),
        .bit_val (cell_bit),
        .ena     (ENA_1MHZ),
        .freeze  (!motor_on),
        .wave    (K7_TAPEIN),
        .done    (cell_done)
    );

endmodule

// File: tb/tb_oric_tape_encoder.sv
// tb/tb_oric_tape_encoder.sv - directed table-driven bench for oric_tape_encoder
module tb_oric_tape_encoder;

    localparam int H     = 8;
    localparam int NCELL = 14;

    logic       CLK_IN    = 1'b0;
    logic       RESET     = 1'b1;
    logic       ENA_1MHZ  = 1'b0;
    logic       motor_on  = 1'b0;
    logic [7:0] tap_data  = 8'h00;
    logic       tap_valid = 1'b0;
    logic       tap_ready;
    logic       busy;
    logic       K7_TAPEIN;

    int checks = 0;
    int errors = 0;

    oric_tape_encoder #(
        .HALF_US   (H),
        .STOP_BITS (4)
    ) dut (
        .CLK_IN    (CLK_IN),
        .RESET     (RESET),
        .ENA_1MHZ  (ENA_1MHZ),
        .motor_on  (motor_on),
        .tap_data  (tap_data),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .busy      (busy),
        .K7_TAPEIN (K7_TAPEIN)
    );

    always #5 CLK_IN = ~CLK_IN;

    // enable every third clock
    int div = 0;
    always @(posedge CLK_IN) begin
        #1;
        div      = (div == 2) ? 0 : div + 1;
        ENA_1MHZ = (div == 0);
    end

    // waveform monitor: measures cells in enables, predicting the events of the next posedge
    int          edge_k = 0, en_cnt = 0, frz_cnt = 0;
    int          last_rise = 0, last_frz = 0, frame_start = 0;
    int          cell_n = 0, frames_done = 0, acc_count = 0;
    int          acc_edge = 0, end_edge = 0, frame_len = 0, hi0 = 0, bad_cells = 0;
    logic [13:0] cells = '0, frame_bits = '0;
    bit          in_frame = 0;
    logic        prev_k7 = 1'b1;

    always @(negedge CLK_IN) begin
        int len;
        edge_k = edge_k + 1;
        if (RESET) in_frame = 0;
        if (K7_TAPEIN === 1'b1 && prev_k7 === 1'b0 && in_frame) begin
            len = (en_cnt - last_rise) - (frz_cnt - last_frz);
            if (len != 2 * H && len != 3 * H) bad_cells = bad_cells + 1;
            cells[cell_n] = (len == 2 * H);
            cell_n    = cell_n + 1;
            last_rise = en_cnt;
            last_frz  = frz_cnt;
            if (cell_n == NCELL) begin
                frame_len   = en_cnt - frame_start;
                frame_bits  = cells;
                end_edge    = edge_k;
                frames_done = frames_done + 1;
                in_frame    = 0;
            end
        end
        if (K7_TAPEIN === 1'b0 && prev_k7 === 1'b1 && in_frame && cell_n == 0)
            hi0 = (en_cnt - last_rise) - (frz_cnt - last_frz);
        prev_k7 = K7_TAPEIN;
        if (ENA_1MHZ) begin
            en_cnt = en_cnt + 1;
            if (!motor_on) frz_cnt = frz_cnt + 1;
        end
        if (tap_valid && tap_ready === 1'b1 && !RESET) begin
            acc_count   = acc_count + 1;
            acc_edge    = edge_k + 1;
            in_frame    = 1;
            cell_n      = 0;
            cells       = '0;
            last_rise   = en_cnt;
            last_frz    = frz_cnt;
            frame_start = en_cnt;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK_IN);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int a;
        a         = acc_count;
        tap_data  = d;
        tap_valid = 1'b1;
        for (int c = 0; c < 200 && acc_count == a; c++) tick(1);
        tap_valid = 1'b0;
        check("accept", 32'(acc_count - a), 32'd1);
    endtask

    task automatic wait_frame(input int f0);
        for (int c = 0; c < 20000 && frames_done == f0; c++) tick(1);
        check("frame_timeout", 32'(frames_done - f0), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  data;
        int          total;
        logic [13:0] cells;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   f0, a, base, held_bad;
        logic k7_held;

        vecs[0] = '{8'h00, 296, 14'h3E00};
        vecs[1] = '{8'hFF, 232, 14'h3FFE};
        vecs[2] = '{8'h01, 296, 14'h3C02};
        vecs[3] = '{8'h16, 280, 14'h3C2C};
        vecs[4] = '{8'hA5, 264, 14'h3F4A};

        RESET    = 1'b1;
        motor_on = 1'b1;
        tick(3);
        check("rst_k7", 32'(K7_TAPEIN), 32'd1);
        check("rst_ready", 32'(tap_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        RESET = 1'b0;
        tick(2);
        check("idle_ready", 32'(tap_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            f0 = frames_done;
            send(vecs[i].data);
            if (i == 0) begin
                check("accept_busy", 32'(busy), 32'd1);
                check("accept_ready", 32'(tap_ready), 32'd0);
            end
            wait_frame(f0);
            if (i == 0) check("high_phase", 32'(hi0), 32'(H));
            check($sformatf("total_%02h", vecs[i].data), 32'(frame_len), 32'(vecs[i].total));
            check($sformatf("cells_%02h", vecs[i].data), 32'(frame_bits), 32'(vecs[i].cells));
            check($sformatf("ready_after_%02h", vecs[i].data), 32'({tap_ready, busy}), 32'b10);
        end

        // back-to-back with tap_valid held
        f0        = frames_done;
        a         = acc_count;
        tap_data  = 8'h01;
        tap_valid = 1'b1;
        for (int c = 0; c < 200 && acc_count == a; c++) tick(1);
        tap_data = 8'h16;
        for (int c = 0; c < 5000 && acc_count < a + 2; c++) tick(1);
        tap_valid = 1'b0;
        check("b2b_accepts", 32'(acc_count - a), 32'd2);
        check("b2b_gap", 32'(acc_edge - end_edge), 32'd1);
        check("b2b_first_cells", 32'(frame_bits), 32'h3C02);
        check("b2b_first_total", 32'(frame_len), 32'd296);
        wait_frame(f0 + 1);
        check("b2b_second_cells", 32'(frame_bits), 32'h3C2C);
        check("b2b_second_total", 32'(frame_len), 32'd280);

        // motor freeze of 1000 enables mid-DATA
        f0 = frames_done;
        send(8'h00);
        for (int c = 0; c < 2000 && cell_n < 4; c++) tick(1);
        tick(5);
        base     = en_cnt;
        motor_on = 1'b0;
        k7_held  = K7_TAPEIN;
        held_bad = 0;
        for (int c = 0; c < 5000 && (en_cnt - base) < 1000; c++) begin
            tick(1);
            if (K7_TAPEIN !== k7_held) held_bad++;
        end
        motor_on = 1'b1;
        check("freeze_k7_held", 32'(held_bad), 32'd0);
        wait_frame(f0);
        check("freeze_total", 32'(frame_len), 32'd1296);
        check("freeze_cells", 32'(frame_bits), 32'h3E00);

        // reset during the parity cell
        f0 = frames_done;
        send(8'hFF);
        for (int c = 0; c < 2000 && cell_n < 9; c++) tick(1);
        tick(3);
        RESET = 1'b1;
        tick(1);
        check("midrst_k7", 32'(K7_TAPEIN), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(tap_ready), 32'd0);
        tick(2);
        RESET = 1'b0;
        tick(2);
        check("postrst_ready", 32'({tap_ready, busy}), 32'b10);
        check("rst_discard", 32'(frames_done - f0), 32'd0);
        send(8'h16);
        wait_frame(f0);
        check("postrst_total", 32'(frame_len), 32'd280);
        check("postrst_cells", 32'(frame_bits), 32'h3C2C);

        // motor off in IDLE blocks acceptance
        motor_on = 1'b0;
        tick(2);
        a         = acc_count;
        tap_data  = 8'h55;
        tap_valid = 1'b1;
        tick(30);
        check("motoroff_ready", 32'(tap_ready), 32'd0);
        check("motoroff_noacc", 32'(acc_count - a), 32'd0);
        check("motoroff_k7", 32'(K7_TAPEIN), 32'd1);
        check("motoroff_busy", 32'(busy), 32'd0);
        tap_valid = 1'b0;
        motor_on  = 1'b1;
        tick(2);

        check("cell_lengths", 32'(bad_cells), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oric_tape_encoder.md
# oric_tape_encoder

Byte-stream-to-cassette-waveform transmitter for the Oric core: takes bytes from a tape-image source (SD/RAM buffer reader) and drives the single-bit cassette input seen by VIA CB1 (`K7_TAPEIN`) with the Oric fast-format waveform. It is the transmit end of the tape path whose receive end is the ROM tape loader running on the VIA. Playback is gated by the cassette motor-relay line (`K7_REMOTE`) and paced by the 1 MHz CPU clock enable.

## Interface
Parameters:
- `HALF_US`, 208, length of one half-cell in 1 MHz enables.
- `STOP_BITS`, 4, number of '1' stop cells after parity.

Ports (one clock; reset is synchronous and active-high):
- `CLK_IN`  in  1  system clock.
- `RESET`  in  1  synchronous active-high reset.
- `ENA_1MHZ`  in  1  1 MHz clock enable, one `CLK_IN` cycle wide.
- `motor_on`  in  1  cassette relay (`K7_REMOTE`); 0 freezes playback.
- `tap_data`  in  8  byte to transmit.
- `tap_valid`  in  1  `tap_data` is valid.
- `tap_ready`  out  1  encoder accepts a byte this cycle.
- `busy`  out  1  a byte frame is in progress.
- `K7_TAPEIN`  out  1  cassette waveform to VIA CB1.

## Operation
- Frame per byte: start cell '0', 8 data cells LSB first, parity cell, `STOP_BITS` '1' cells.
- Parity cell = 1 when `tap_data` has an even number of ones (odd overall parity), else 0.
- Cell encoding, in `ENA_1MHZ` ticks: high phase `HALF_US`; low phase `HALF_US` for '1', `2*HALF_US` for '0'. '1' cell = 416 µs, '0' cell = 624 µs at default.
- FSM: IDLE -> START -> DATA (bit index 0..7) -> PARITY -> STOP (count 0..STOP_BITS-1) -> IDLE.
- IDLE: `K7_TAPEIN`=1, `busy`=0, `tap_ready` = `motor_on`. Accept on `tap_valid && tap_ready`; latch byte and parity; go to START.
- Each non-IDLE state advances when its cell's low phase completes.
- `motor_on`=0 in any non-IDLE state: tick counter, phase, and `K7_TAPEIN` hold; resume exactly where frozen when `motor_on` returns to 1.
- `tap_valid` without `tap_ready`: no effect, byte not consumed; source must hold data stable.
- Reset values: `K7_TAPEIN`=1, `tap_ready`=0, `busy`=0, state IDLE, counters 0.

## Timing
- Accept cycle N: state START and `busy`=1 from cycle N+1; `tap_ready`=0 from N+1.
- `K7_TAPEIN` stays 1 through the high phase; drops to 0 on the `CLK_IN` cycle of the `HALF_US`-th enable after cell start; rises on the enable ending the low phase (start of next cell).
- Last stop cell end: one `CLK_IN` cycle in IDLE (`tap_ready`=1 if motor on); back-to-back bytes lose < 1 µs, no extra enable.
- Byte duration = sum of cell lengths, exact to the enable (0x00: 7696 µs; 0xFF: 6032 µs).
- `RESET` mid-frame: next cycle is reset state; partial byte discarded, not re-requested.
- Tick counter width 10 bits (max count `2*HALF_US`=416); counts compare with `== limit-1`, no wrap.

## Structure
- Shared package `oric_pkg`: tape-state enum (IDLE, START, DATA, PARITY, STOP), default `HALF_US`/`STOP_BITS` constants.
- One sub-module `tape_bit_cell`: given `start`, `bit`, enable and freeze, produces the cell waveform and a one-cycle `done`; FSM in the top sequences bits.

## Test plan
- Send 0x00 with motor on -> cells 0,0×8,parity 1,1×4; `K7_TAPEIN` low phases 416/.../208; total 7696 enables; `tap_ready` back high after.
- Send 0xFF -> parity 1, all '1' cells except start; total 6032 enables.
- Send 0x01 then 0x16 back-to-back with `tap_valid` held -> second accept exactly one `CLK_IN` after first frame ends; 0x16 parity 0 (three ones), measured cell sequence matches LSB-first.
- Drop `motor_on` for 1000 enables mid-DATA -> `K7_TAPEIN` and counters frozen; frame total = nominal + 1000 enables; bits unchanged.
- Assert `RESET` during PARITY -> next cycle `K7_TAPEIN`=1, `busy`=0, `tap_ready`=0; after release with motor on, `tap_ready`=1 and new byte encodes correctly.
- `motor_on`=0 in IDLE with `tap_valid`=1 -> `tap_ready`=0, no accept, output stays 1.
